seq_bundler_array: RTL
======================

// Module: seq_bundler_array
// PURPOSE
//  Multi-lane sequential bundler for the sparse HDC encoder. Accepts a sample's
//  FEATURE_COUNT bound bits per lane as a stream of CHUNK_WIDTH-bit beats, popcounts
//  and accumulates each lane, then thresholds the lane sums into one encoded
//  hypervector slice of LANES bits. Sits between the binding stage and the class-HV
//  memory; generalises the single-lane, fixed-4-bit, fixed-10-cycle bundler.
// PARAMETERS
//  FEATURE_COUNT  617  features bundled per lane per sample
//  CHUNK_WIDTH    64   feature bits per lane per input beat
//  LANES          8    hypervector dimensions processed in parallel
//  NUM_CHUNKS     ceil(FEATURE_COUNT/CHUNK_WIDTH), derived (localparam)
//  ACC_W          $clog2(FEATURE_COUNT+1), derived (localparam)
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst        in   1                  synchronous, active-high reset
//  en         in   1                  global enable; 0 freezes all state
//  start      in   1                  pulse: begin a new sample (honoured only in IDLE)
//  thr        in   ACC_W              encoding threshold, sampled on accepted start
//  in_valid   in   1                  in_chunk holds a valid beat
//  in_ready   out  1                  block accepts a beat this cycle
//  in_chunk   in   LANES*CHUNK_WIDTH  lane l at [l*CHUNK_WIDTH +: CHUNK_WIDTH]
//  out_valid  out  1                  out_bits holds a finished result
//  out_ready  in   1                  consumer accepts result
//  out_bits   out  LANES              thresholded bit per lane
//  busy       out  1                  state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at clk edge, any state): state=IDLE, acc[*]=0, chunk_cnt=0,
//    thr_q=0, out_valid=0, out_bits=0, in_ready=0, busy=0. Mid-sample reset drops sample.
//  - en=0: no state/register changes; in_ready forced 0; out_valid held; no transfer.
//  - Beat accepted: in_valid & in_ready. Result transfer: out_valid & out_ready & en.
//  - FSM IDLE -> ACCUM -> HOLD -> IDLE:
//    IDLE : in_ready=0. start&en: acc[*]<=0, chunk_cnt<=0, thr_q<=thr, -> ACCUM.
//    ACCUM: in_ready=en. Per accepted beat, acc[l] <= acc[l] + popcount(masked chunk l),
//           chunk_cnt++. On beat with chunk_cnt==NUM_CHUNKS-1: out_bits[l] <=
//           (acc[l]+popcount >= thr_q), out_valid<=1, chunk_cnt<=0, -> HOLD.
//           No accepted beat: hold. start ignored.
//    HOLD : out_valid=1, out_bits stable; on transfer out_valid<=0, -> IDLE. start ignored.
//  - Latency: out_valid rises the cycle after the last beat is accepted.
//  - Masking: on last beat only bits [FEATURE_COUNT-(NUM_CHUNKS-1)*CHUNK_WIDTH-1:0]
//    of each lane count; upper bits ignored regardless of value.
//  - Widths: per-beat popcount $clog2(CHUNK_WIDTH+1); acc ACC_W bits, cannot overflow.
//  - thr_q fixed for the sample; thr changes after start have no effect.
//    thr_q==0 -> all out_bits=1; thr_q>FEATURE_COUNT -> all out_bits=0.
//  - Popcount is combinational tree (generate loop), single cycle per beat.
//  - out_bits retain last value after transfer until next result.
// CONFIGURATION
//  SEQ_BUNDLER_SUM_OUT_EN defined: extra port out_sum [LANES*ACC_W] out, final lane
//    sums registered alongside out_bits, same valid/hold rules, reset 0.
//  Undefined: port and its registers absent; out_bits behaviour identical.
// TESTING (FEATURE_COUNT=10, CHUNK_WIDTH=4, LANES=2 -> NUM_CHUNKS=3, ACC_W=4)
//  - Lane0 all 1s, lane1 bits 1010101010, thr=5, 3 back-to-back beats -> out_valid 1
//    cycle after beat 3, out_bits=2'b11 (sums 10,5; >= inclusive).
//  - Same, thr=6; last beat lane chunks 4'b1111 (bits [3:2] beyond F) -> out_bits=2'b01,
//    masked bits not counted (sum_out 10,5 when SEQ_BUNDLER_SUM_OUT_EN).
//  - in_valid gaps + out_ready low 5 cycles -> sums unaffected, out_valid/out_bits held,
//    start pulses in ACCUM/HOLD ignored; IDLE only after out_ready.
//  - en=0 for 3 cycles mid-ACCUM with in_valid=1 -> in_ready=0, no beats consumed.
//  - rst after beat 2 -> all outputs 0, IDLE; new sample (all-zero lanes, thr=1) -> 2'b00.
//  - thr changed to 0 after start -> result uses sampled thr; thr=0 sample -> 2'b11.

Source files
------------

// File: rtl/seq_bundler_array.sv
// rtl/seq_bundler_array.sv - multi-lane sequential popcount bundler with threshold encoding
//
// Purpose:
//   Collects FEATURE_COUNT bound bits per lane as NUM_CHUNKS beats of CHUNK_WIDTH
//   bits. For each lane it popcounts every beat and adds it to a running sum. On the
//   last beat it compares each lane sum against the threshold captured at start.
//   The result is one encoded hypervector slice of LANES bits.
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst        synchronous active-high reset
//   en         global enable; low freezes every register and blocks transfers
//   start      begin a new sample (honoured only when idle)
//   thr        threshold, captured when start is accepted
//   in_valid   in_chunk carries a valid beat
//   in_ready   beat is accepted this cycle (accumulating and enabled)
//   in_chunk   lane l at [l*CHUNK_WIDTH +: CHUNK_WIDTH]
//   out_valid  out_bits holds a finished result
//   out_ready  consumer accepts the result
//   out_bits   one thresholded bit per lane
//   busy       a sample is in flight or a result is pending
//   out_sum    (only with SEQ_BUNDLER_SUM_OUT_EN) final lane sums, ACC_W bits per lane
//
// Configuration macro: SEQ_BUNDLER_SUM_OUT_EN adds the out_sum port and its registers.

module seq_bundler_array #(
  parameter int FEATURE_COUNT = 617,
  parameter int CHUNK_WIDTH   = 64,
  parameter int LANES         = 8,
  localparam int NUM_CHUNKS   = (FEATURE_COUNT + CHUNK_WIDTH - 1) / CHUNK_WIDTH,
  localparam int ACC_W        = $clog2(FEATURE_COUNT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [ACC_W-1:0]             thr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*CHUNK_WIDTH-1:0] in_chunk,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_bits,
  output logic                         busy
`ifdef SEQ_BUNDLER_SUM_OUT_EN
  ,
  output logic [LANES*ACC_W-1:0]       out_sum
`endif
);

  localparam int PC_W      = $clog2(CHUNK_WIDTH + 1);
  localparam int CNT_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int LAST_BITS = FEATURE_COUNT - (NUM_CHUNKS - 1) * CHUNK_WIDTH;

  // Only the low LAST_BITS of each lane are real features on the final beat.
  localparam logic [CHUNK_WIDTH-1:0] LAST_MASK =
    {CHUNK_WIDTH{1'b1}} >> (CHUNK_WIDTH - LAST_BITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]                   state;
  logic [CNT_W-1:0]             chunk_cnt;
  logic [ACC_W-1:0]             thr_q;
  logic [LANES-1:0][ACC_W-1:0]  acc;
  logic [LANES-1:0][ACC_W-1:0]  acc_next;
  logic [LANES-1:0]             lane_hit;
  logic                         is_last;

  assign is_last  = (chunk_cnt == LAST_IDX);
  assign in_ready = (state == ACCUM) && en;
  assign busy     = (state != IDLE);

  // Per-lane masked popcount and candidate sum; all lanes evaluate in one cycle.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CHUNK_WIDTH-1:0] masked;
    logic [PC_W-1:0]        pc;

    assign masked = in_chunk[l*CHUNK_WIDTH +: CHUNK_WIDTH] &
                    (is_last ? LAST_MASK : {CHUNK_WIDTH{1'b1}});

    always_comb begin
      pc = '0;
      for (int b = 0; b < CHUNK_WIDTH; b++) begin
        pc = pc + PC_W'(masked[b]);
      end
    end

    // Total masked count never exceeds FEATURE_COUNT, so ACC_W bits always suffice.
    assign acc_next[l] = acc[l] + ACC_W'(pc);
    assign lane_hit[l] = (acc_next[l] >= thr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      chunk_cnt <= '0;
      thr_q     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_bits  <= '0;
`ifdef SEQ_BUNDLER_SUM_OUT_EN
      out_sum   <= '0;
`endif
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            chunk_cnt <= '0;
            thr_q     <= thr;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            if (is_last) begin
              out_bits  <= lane_hit;
              out_valid <= 1'b1;
              chunk_cnt <= '0;
              state     <= HOLD;
`ifdef SEQ_BUNDLER_SUM_OUT_EN
              out_sum   <= acc_next;
`endif
            end else begin
              chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
